// File: rtl/sar_pkg.sv
// Shared definitions for the SAR sample sequencer: FSM state type and default sizing.
package sar_pkg;

    localparam int unsigned SAR_DW      = 8;
    localparam int unsigned SAR_DEPTH   = 8;
    localparam int unsigned SAR_TMO_CYC = 64;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StStart,
        StConv,
        StCapt
    } sar_state_e;

endpackage

// File: rtl/sar_sample_seq_if.sv
// Handshake bundle between the sequencer, the SAR controller and the sample reader.
interface sar_sample_seq_if #(
    parameter int unsigned DW = sar_pkg::SAR_DW
);
    logic          adc_start;
    logic          adc_done;
    logic [DW-1:0] adc_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;

    modport master (
        output adc_start,
        input  adc_done,
        input  adc_data,
        output rd_valid,
        input  rd_ready,
        output rd_data
    );

    modport slave (
        input  adc_start,
        output adc_done,
        output adc_data,
        input  rd_valid,
        output rd_ready,
        input  rd_data
    );
endinterface

// File: rtl/sar_sample_fifo.sv
// Synchronous first-word-fall-through sample FIFO; a pop in the same cycle frees room for a push.
module sar_sample_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    input  logic                     pop,
    output logic                     valid,
    output logic [DW-1:0]            rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] FULL_LVL = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_cnt_q, rd_cnt_q;
    logic          empty, full, do_push, do_pop;

    assign level   = wr_cnt_q - rd_cnt_q;
    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & ~do_push;
    assign valid   = ~empty;
    assign rdata   = empty ? '0 : mem[rd_cnt_q[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (clr) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (do_push) wr_cnt_q <= wr_cnt_q + CW'(1);
            if (do_pop)  rd_cnt_q <= rd_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_cnt_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sar_sample_seq.sv
// SAR conversion sequencer: free-run / one-shot start pulses, done-edge capture into a FIFO.
module sar_sample_seq
    import sar_pkg::*;
#(
    parameter int unsigned DW      = SAR_DW,
    parameter int unsigned DEPTH   = SAR_DEPTH,
    parameter int unsigned TMO_CYC = SAR_TMO_CYC
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   en,
    input  logic                   oneshot,
    input  logic [15:0]            period,
    input  logic                   clr,
    sar_sample_seq_if.master       bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    output logic                   tmo_err
);
    localparam int unsigned TW       = $clog2(TMO_CYC + 1);
    localparam int unsigned TMO_LAST = TMO_CYC - 1;
    localparam logic [TW-1:0] TMO_END = TMO_LAST[TW-1:0];

    sar_state_e    state_q, state_d;
    logic [15:0]   wait_q, wait_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [DW-1:0] data_q, data_d;
    logic          done_q, done_rise, push, drop;
    logic          ovf_q, ovf_d, tmo_err_q, tmo_err_d;
    logic          fifo_valid;
    logic [DW-1:0] fifo_rdata;

    // Only a fresh 0->1 edge completes a conversion; a level left over from before does not.
    assign done_rise = bus.adc_done & ~done_q;
    assign push      = (state_q == StCapt);

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        tmo_err_d = tmo_err_q;
        ovf_d     = ovf_q | drop;
        case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StWait;
                    wait_d  = period;
                end else if (oneshot) begin
                    state_d = StStart;
                end
            end
            StWait: begin
                if (!en)                 state_d = StIdle;
                else if (wait_q == '0)   state_d = StStart;
                else                     wait_d  = wait_q - 16'd1;
            end
            StStart: begin
                state_d = StConv;
                tmo_d   = '0;
            end
            StConv: begin
                tmo_d = tmo_q + TW'(1);
                if (done_rise) begin
                    state_d = StCapt;
                    data_d  = bus.adc_data;
                end else if (tmo_d == TMO_END) begin
                    state_d   = StIdle;
                    tmo_err_d = 1'b1;
                end
            end
            StCapt: begin
                if (en) begin
                    state_d = StWait;
                    wait_d  = period;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (clr) begin
            state_d   = StIdle;
            ovf_d     = 1'b0;
            tmo_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            tmo_q     <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            done_q    <= bus.adc_done;
            ovf_q     <= ovf_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    sar_sample_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clr),
        .push  (push),
        .wdata (data_q),
        .pop   (bus.rd_ready),
        .valid (fifo_valid),
        .rdata (fifo_rdata),
        .level (level),
        .drop  (drop)
    );

    assign bus.adc_start = (state_q == StStart);
    assign bus.rd_valid  = fifo_valid;
    assign bus.rd_data   = fifo_rdata;
    assign ovf           = ovf_q;
    assign tmo_err       = tmo_err_q;

endmodule

// File: tb/tb_sar_sample_seq.sv
// Bench for sar_sample_seq: SAR responder, queue-based reference model, directed and random runs.
module tb_sar_sample_seq;
    localparam int DEPTH   = 8;
    localparam int TMO_CYC = 64;

    typedef enum int {MIdle, MWait, MStart, MConv, MCapt} mphase_e;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en, oneshot, clr;
    logic [15:0] period;
    logic [3:0]  level;
    logic        ovf, tmo_err;

    sar_sample_seq_if #(.DW(8)) bus ();

    sar_sample_seq #(.DW(8), .DEPTH(DEPTH), .TMO_CYC(TMO_CYC)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .oneshot (oneshot),
        .period  (period),
        .clr     (clr),
        .bus     (bus),
        .level   (level),
        .ovf     (ovf),
        .tmo_err (tmo_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    mphase_e    m_ph;
    logic [7:0] m_q[$];
    logic [7:0] m_cap;
    int         m_wait, m_age;
    bit         m_ovf, m_tmo, m_dprev;

    function automatic void model_reset();
        m_q.delete();
        m_ph = MIdle; m_cap = 8'h00; m_wait = 0; m_age = 0;
        m_ovf = 0; m_tmo = 0; m_dprev = 0;
    endfunction

    function automatic void model_step();
        bit rise = bus.adc_done && !m_dprev;
        if (clr) begin
            m_q.delete();
            m_ovf = 0; m_tmo = 0; m_ph = MIdle;
        end else begin
            if (bus.rd_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (m_ph == MCapt) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_cap);
                else m_ovf = 1;
            end
            case (m_ph)
                MIdle:  if (en) begin m_ph = MWait; m_wait = int'(period); end
                        else if (oneshot) m_ph = MStart;
                MWait:  if (!en) m_ph = MIdle;
                        else if (m_wait == 0) m_ph = MStart;
                        else m_wait--;
                MStart: begin m_ph = MConv; m_age = 0; end
                MConv: begin
                    m_age++;  // cycles elapsed since the start pulse
                    if (rise) begin m_cap = bus.adc_data; m_ph = MCapt; end
                    else if (m_age == TMO_CYC - 1) begin m_tmo = 1; m_ph = MIdle; end
                end
                MCapt:  if (en) begin m_ph = MWait; m_wait = int'(period); end
                        else m_ph = MIdle;
                default: m_ph = MIdle;
            endcase
        end
        m_dprev = bus.adc_done;
    endfunction

    always @(negedge clk) begin
        if (!rstn) model_reset();
        chk("adc_start", bus.adc_start, m_ph == MStart);
        chk("rd_valid", bus.rd_valid, m_q.size() > 0);
        chk("rd_data", bus.rd_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
        chk("level", level, m_q.size());
        chk("ovf", ovf, m_ovf);
        chk("tmo_err", tmo_err, m_tmo);
        if (rstn) model_step();
    end

    // ---------------- SAR controller responder ----------------
    int         sar_lat = 10;   // -1: never completes
    bit         sar_fix = 0;
    logic [7:0] sar_fix_val = 8'h00;
    logic [7:0] sar_hist[$];

    initial begin
        int         scnt;
        logic       nd;
        logic [7:0] ndata;
        bus.adc_done = 1'b0;
        bus.adc_data = 8'h00;
        scnt = -1;
        forever begin
            @(negedge clk);
            nd    = bus.adc_done;
            ndata = bus.adc_data;
            if (bus.adc_start) begin
                nd   = 1'b0;
                scnt = (sar_lat < 0) ? -1 : sar_lat - 1;
            end
            if (scnt == 0) begin
                nd    = 1'b1;
                ndata = sar_fix ? sar_fix_val : 8'($urandom);
                sar_hist.push_back(ndata);
            end
            if (scnt >= 0) scnt--;
            @(posedge clk);
            #1;
            bus.adc_done = nd;
            bus.adc_data = ndata;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int maxc, input string tag);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.adc_start && k < maxc);
        chk(tag, bus.adc_start, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   starts, last, k, rd_mode;
        logic prev;
        rstn = 1'b0; en = 1'b0; oneshot = 1'b0; clr = 1'b0; period = 16'd0;
        bus.rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_start", bus.adc_start, 1'b0);
        chk("rst_valid", bus.rd_valid, 1'b0);
        chk("rst_level", level, 4'd0);
        chk("rst_flags", {ovf, tmo_err}, 2'b00);
        tick(); rstn = 1'b1;

        // single shot with fixed result 0xA5
        sar_fix = 1; sar_fix_val = 8'hA5;
        tick(); oneshot = 1'b1;
        tick(); oneshot = 1'b0;
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.adc_start) starts++;
        end
        chk("os_starts", starts, 1);
        chk("os_valid", bus.rd_valid, 1'b1);
        chk("os_data", bus.rd_data, 8'hA5);
        chk("os_level", level, 4'd1);
        chk("os_flags", {ovf, tmo_err}, 2'b00);
        tick(); bus.rd_ready = 1'b1;
        tick(); bus.rd_ready = 1'b0;
        sar_fix = 0;

        // free-run period 3, latency 10: one start every 16 cycles
        period = 16'd3; bus.rd_ready = 1'b1;
        tick(); en = 1'b1;
        wait_start(20, "fr_first");
        last = cyc;
        for (int i = 0; i < 4; i++) begin
            wait_start(40, "fr_next");
            chk("fr_interval", cyc - last, 16);
            last = cyc;
        end
        tick(); en = 1'b0;
        repeat (30) tick();

        // no reader: 10 conversions overflow an 8-deep FIFO
        clr = 1'b1; tick(); clr = 1'b0;
        bus.rd_ready = 1'b0;
        sar_hist.delete();
        en = 1'b1;
        for (int i = 0; i < 10; i++) wait_start(40, "ovf_start");
        repeat (13) tick();
        en = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("ovf_level", level, 4'd8);
        chk("ovf_flag", ovf, 1'b1);
        tick(); bus.rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("drain_data", bus.rd_data, sar_hist[i]);
            tick();
        end
        bus.rd_ready = 1'b0;
        @(negedge clk);
        chk("drain_level", level, 4'd0);

        // done never arrives
        tick(); clr = 1'b1;
        tick(); clr = 1'b0; sar_lat = -1; oneshot = 1'b1;
        tick(); oneshot = 1'b0;
        wait_start(10, "tmo_start");
        last = cyc; k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tmo_err && k < 200);
        chk("tmo_seen", tmo_err, 1'b1);
        chk("tmo_latency", cyc - last, TMO_CYC);
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.adc_start) starts++;
        end
        chk("tmo_idle", starts, 0);
        sar_lat = 10;

        // full FIFO, capture coincides with a pop
        tick(); clr = 1'b1;
        tick(); clr = 1'b0; en = 1'b1; period = 16'd3;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (level != 4'd8 && k < 300);
        chk("full_reach", level, 4'd8);
        chk("full_noovf", ovf, 1'b0);
        prev = bus.adc_done; k = 0;
        do begin
            prev = bus.adc_done;
            @(negedge clk);
            k++;
        end while (!(bus.adc_done && !prev) && k < 60);
        chk("full_rise", bus.adc_done, 1'b1);
        tick(); bus.rd_ready = 1'b1;
        tick(); bus.rd_ready = 1'b0; en = 1'b0;
        @(negedge clk);
        chk("fullpop_level", level, 4'd8);
        chk("fullpop_ovf", ovf, 1'b0);

        // clr mid-conversion, then a late done
        sar_lat = 30;
        tick(); oneshot = 1'b1;
        tick(); oneshot = 1'b0;
        wait_start(10, "clr_start");
        repeat (5) tick();
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (40) tick();
        @(negedge clk);
        chk("clr_level", level, 4'd0);
        chk("clr_valid", bus.rd_valid, 1'b0);
        chk("clr_flags", {ovf, tmo_err}, 2'b00);

        // async reset mid-conversion
        sar_lat = 10;
        tick(); oneshot = 1'b1;
        tick(); oneshot = 1'b0;
        repeat (20) tick();
        oneshot = 1'b1;
        tick(); oneshot = 1'b0;
        wait_start(10, "rst_conv_start");
        repeat (3) tick();
        rstn = 1'b0;
        @(negedge clk);
        chk("rstm_level", level, 4'd0);
        chk("rstm_valid", bus.rd_valid, 1'b0);
        chk("rstm_data", bus.rd_data, 8'h00);
        chk("rstm_start", bus.adc_start, 1'b0);
        tick(); rstn = 1'b1;

        // randomized traffic, checked cycle by cycle against the model
        rd_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!rstn) rstn = 1'b1;
            else if ($urandom_range(0, 999) == 0) rstn = 1'b0;
            if (i % 256 == 0) rd_mode = $urandom_range(0, 1);
            if ($urandom_range(0, 63) == 0) en = ~en;
            if ($urandom_range(0, 99) == 0) period = 16'($urandom_range(0, 6));
            oneshot      = ($urandom_range(0, 15) == 0);
            clr          = ($urandom_range(0, 299) == 0);
            bus.rd_ready = rd_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            sar_lat      = ($urandom_range(0, 40) == 0) ? -1 : int'($urandom_range(2, 20));
        end
        tick();
        rstn = 1'b1; en = 1'b0; oneshot = 1'b0; clr = 1'b0; bus.rd_ready = 1'b0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
